// File: rtl/passcode_pkg.sv
// +--------------------------------------------------------------------+
// | passcode_pkg : shared states, key codes and default password        |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
`default_nettype none

package passcode_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ENTRY = 3'd1,
      ST_CHECK = 3'd2,
      ST_SET   = 3'd3,
      ST_LOCK  = 3'd4
   } state_e;

   localparam logic [3:0] KEY_NONE = 4'd0;
   localparam logic [3:0] KEY_1    = 4'd1;
   localparam logic [3:0] KEY_3    = 4'd3;
   localparam logic [3:0] KEY_7    = 4'd7;
   localparam logic [3:0] KEY_9    = 4'd9;

   localparam logic [15:0] DEFAULT_PW = 16'h1379;

endpackage

`default_nettype wire

// File: rtl/passcode_ctrl_key_filter.sv
// +--------------------------------------------------------------------+
// | key_event_filter : turns one stable key hold into one key_evt pulse |
// | Revision         : 1.0                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module key_event_filter
   import passcode_pkg::*;
#(
   parameter int STABLE_CYC = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] scan_in,
   output logic       key_evt,
   output logic [3:0] key_val
);

   localparam int CW = $clog2(STABLE_CYC + 1);

   logic          armed_q, armed_d;
   logic [3:0]    last_q, last_d;
   logic [CW-1:0] run_q, run_d;
   logic [CW-1:0] w_run_next;

   // A sample that differs from the previous one starts a fresh run of length 1.
   assign w_run_next = ((run_q != '0) && (scan_in == last_q)) ? run_q + CW'(1) : CW'(1);
   assign key_val    = scan_in;

   always_comb begin
      armed_d = armed_q;
      last_d  = last_q;
      run_d   = run_q;
      key_evt = 1'b0;
      if (scan_in == KEY_NONE) begin
         armed_d = 1'b1;
         run_d   = '0;
      end else if (armed_q) begin
         last_d = scan_in;
         if (w_run_next == CW'(STABLE_CYC)) begin
            key_evt = 1'b1;
            armed_d = 1'b0;
            run_d   = '0;
         end else begin
            run_d = w_run_next;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         armed_q <= 1'b1;
         last_q  <= KEY_NONE;
         run_q   <= '0;
      end else begin
         armed_q <= armed_d;
         last_q  <= last_d;
         run_q   <= run_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/passcode_ctrl.sv
// +--------------------------------------------------------------------+
// | passcode_ctrl : keypad passcode check, password change, timeout     |
// | Optional failed-attempt lockout enabled by macro LOCKOUT_EN.        |
// | Revision      : 1.0                                                 |
// +--------------------------------------------------------------------+
`default_nettype none

module passcode_ctrl
   import passcode_pkg::*;
#(
   parameter int                  DIGITS      = 4,
   parameter int                  STABLE_CYC  = 4,
   parameter int                  TIMEOUT_CYC = 1000,
   parameter logic [DIGITS*4-1:0] DEFAULT_PW  = passcode_pkg::DEFAULT_PW,
   parameter int                  MAX_FAIL    = 3,
   parameter int                  LOCK_CYC    = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [3:0]                   scan_in,
   input  logic                         cmd_set,
   output logic                         unlock,
   output logic                         fail,
   output logic                         set_done,
   output logic                         locked_out,
   output logic                         busy,
   output logic [$clog2(DIGITS+1)-1:0]  digit_cnt
);

   localparam int BW    = DIGITS * 4;
   localparam int CNT_W = $clog2(DIGITS + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

   if (DIGITS < 2 || DIGITS > 8 || STABLE_CYC < 1 || TIMEOUT_CYC < 1 ||
       MAX_FAIL < 1 || LOCK_CYC < 1) begin : g_bad_params
      $error("passcode_ctrl: parameter out of range");
   end

   logic       key_evt;
   logic [3:0] key_val;

   key_event_filter #(
      .STABLE_CYC (STABLE_CYC)
   ) u_filter (
      .clk     (clk),
      .rst     (rst),
      .scan_in (scan_in),
      .key_evt (key_evt),
      .key_val (key_val)
   );

   state_e           state_q, state_d;
   logic [BW-1:0]    buf_q, buf_d;
   logic [BW-1:0]    pw_q, pw_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic             auth_q, auth_d;
   logic             unlock_q, unlock_d;
   logic             fail_q, fail_d;
   logic             set_done_q, set_done_d;
   logic [BW-1:0]    w_buf_shift;

`ifdef LOCKOUT_EN
   localparam int FAIL_W = $clog2(MAX_FAIL + 1);
   localparam int LOCK_W = $clog2(LOCK_CYC + 1);
   logic [FAIL_W-1:0] fail_cnt_q, fail_cnt_d;
   logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
`endif

   assign w_buf_shift = {buf_q[BW-5:0], key_val};

   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      pw_d       = pw_q;
      cnt_d      = cnt_q;
      timer_d    = timer_q;
      auth_d     = auth_q;
      unlock_d   = 1'b0;
      fail_d     = 1'b0;
      set_done_d = 1'b0;
`ifdef LOCKOUT_EN
      fail_cnt_d = fail_cnt_q;
      lock_cnt_d = lock_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (cmd_set && auth_q) begin
               state_d = ST_SET;
               buf_d   = '0;
               cnt_d   = '0;
               timer_d = '0;
            end else if (key_evt) begin
               state_d = ST_ENTRY;
               buf_d   = w_buf_shift;
               cnt_d   = CNT_W'(1);
               timer_d = '0;
            end
         end
         ST_ENTRY, ST_SET: begin
            if (key_evt) begin
               buf_d   = w_buf_shift;
               cnt_d   = cnt_q + CNT_W'(1);
               timer_d = '0;
               if (cnt_q == CNT_W'(DIGITS - 1)) begin
                  if (state_q == ST_SET) begin
                     pw_d       = w_buf_shift;
                     set_done_d = 1'b1;
                     auth_d     = 1'b0;
                     state_d    = ST_IDLE;
                     buf_d      = '0;
                     cnt_d      = '0;
                  end else begin
                     state_d = ST_CHECK;
                  end
               end
            end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
               state_d = ST_IDLE;
               buf_d   = '0;
               cnt_d   = '0;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         ST_CHECK: begin
            state_d = ST_IDLE;
            buf_d   = '0;
            cnt_d   = '0;
            if (buf_q == pw_q) begin
               unlock_d = 1'b1;
               auth_d   = 1'b1;
`ifdef LOCKOUT_EN
               fail_cnt_d = '0;
`endif
            end else begin
               fail_d = 1'b1;
               auth_d = 1'b0;
`ifdef LOCKOUT_EN
               fail_cnt_d = fail_cnt_q + FAIL_W'(1);
               if (fail_cnt_q == FAIL_W'(MAX_FAIL - 1)) begin
                  state_d    = ST_LOCK;
                  lock_cnt_d = '0;
               end
`endif
            end
         end
`ifdef LOCKOUT_EN
         ST_LOCK: begin
            if (lock_cnt_q == LOCK_W'(LOCK_CYC - 1)) begin
               state_d    = ST_IDLE;
               fail_cnt_d = '0;
               lock_cnt_d = '0;
            end else begin
               lock_cnt_d = lock_cnt_q + LOCK_W'(1);
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            buf_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         buf_q      <= '0;
         pw_q       <= DEFAULT_PW;
         cnt_q      <= '0;
         timer_q    <= '0;
         auth_q     <= 1'b0;
         unlock_q   <= 1'b0;
         fail_q     <= 1'b0;
         set_done_q <= 1'b0;
`ifdef LOCKOUT_EN
         fail_cnt_q <= '0;
         lock_cnt_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         pw_q       <= pw_d;
         cnt_q      <= cnt_d;
         timer_q    <= timer_d;
         auth_q     <= auth_d;
         unlock_q   <= unlock_d;
         fail_q     <= fail_d;
         set_done_q <= set_done_d;
`ifdef LOCKOUT_EN
         fail_cnt_q <= fail_cnt_d;
         lock_cnt_q <= lock_cnt_d;
`endif
      end
   end

   assign unlock    = unlock_q;
   assign fail      = fail_q;
   assign set_done  = set_done_q;
   assign busy      = (state_q != ST_IDLE);
   assign digit_cnt = cnt_q;
`ifdef LOCKOUT_EN
   assign locked_out = (state_q == ST_LOCK);
`else
   assign locked_out = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_passcode_ctrl.sv
// +--------------------------------------------------------------------+
// | tb_passcode_ctrl : scoreboard bench for passcode_ctrl               |
// | Revision         : 1.0                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_passcode_ctrl;

   localparam int          LOCK_CYC    = 16;
   localparam int          TIMEOUT_CYC = 1000;
   localparam logic [2:0]  EV_UNLOCK   = 3'b100;
   localparam logic [2:0]  EV_FAIL     = 3'b010;
   localparam logic [2:0]  EV_SET      = 3'b001;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] scan_in = 4'd0;
   logic       cmd_set = 1'b0;
   logic       unlock, fail, set_done, locked_out, busy;
   logic [2:0] digit_cnt;

   int         checks = 0;
   int         errors = 0;
   logic [2:0] exp_q[$];
   int         lock_run = 0;
   int         lock_runs = 0;

   passcode_ctrl #(
      .DIGITS      (4),
      .STABLE_CYC  (4),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .DEFAULT_PW  (16'h1379),
      .MAX_FAIL    (3),
      .LOCK_CYC    (LOCK_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .scan_in    (scan_in),
      .cmd_set    (cmd_set),
      .unlock     (unlock),
      .fail       (fail),
      .set_done   (set_done),
      .locked_out (locked_out),
      .busy       (busy),
      .digit_cnt  (digit_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Event monitor: pops one expectation per output pulse; also times lockout runs.
   always @(negedge clk) begin
      logic [2:0] ev;
      logic [2:0] e;
      ev = {unlock, fail, set_done};
      if (ev != 3'b000) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL event: got %b, expected no event", ev);
         end else begin
            e = exp_q.pop_front();
            check("event", int'(ev), int'(e));
         end
      end
      if (locked_out) begin
         lock_run++;
      end else if (lock_run != 0) begin
         check("lock_len", lock_run, LOCK_CYC);
         lock_runs++;
         lock_run = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] d, input int hold);
      scan_in = d;
      repeat (hold) tick();
      scan_in = 4'd0;
      repeat (2) tick();
   endtask

   task automatic enter(input logic [15:0] code, input logic [2:0] ev);
      logic [15:0] c;
      c = code;
      exp_q.push_back(ev);
      for (int i = 0; i < 4; i++) press(c[15-4*i -: 4], 6);
      @(negedge clk);
      check("digit_cnt_after_entry", int'(digit_cnt), 0);
   endtask

   task automatic pulse_cmd_set();
      cmd_set = 1'b1;
      tick();
      cmd_set = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_unlock"}, int'(unlock), 0);
      check({tag, "_fail"}, int'(fail), 0);
      check({tag, "_set_done"}, int'(set_done), 0);
      check({tag, "_locked_out"}, int'(locked_out), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_digit_cnt"}, int'(digit_cnt), 0);
   endtask

   initial begin
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset");

      // First digit latency: count updates STABLE_CYC cycles after first sample.
      exp_q.push_back(EV_UNLOCK);
      scan_in = 4'd1;
      repeat (3) tick();
      @(negedge clk);
      check("latency_before", int'(digit_cnt), 0);
      tick();
      @(negedge clk);
      check("latency_at", int'(digit_cnt), 1);
      check("busy_in_entry", int'(busy), 1);
      tick(); tick();
      scan_in = 4'd0;
      repeat (2) tick();
      press(4'd3, 6);
      press(4'd7, 6);
      press(4'd9, 6);
      @(negedge clk);
      check("t1_digit_cnt", int'(digit_cnt), 0);

      // Three wrong entries.
      enter(16'h1111, EV_FAIL);
      enter(16'h1111, EV_FAIL);
      enter(16'h1111, EV_FAIL);
`ifdef LOCKOUT_EN
      check("locked_after_3", int'(locked_out), 1);
      press(4'd1, 6);
      @(negedge clk);
      check("lock_key_ignored", int'(digit_cnt), 0);
      begin
         int n;
         n = 0;
         while (locked_out && n < 100) begin
            tick();
            n++;
         end
         check("lock_release_bound", int'(locked_out), 0);
      end
      tick();
`endif
      enter(16'h1379, EV_UNLOCK);

      // Long hold counts once; short glitch counts never.
      press(4'd7, 20);
      @(negedge clk);
      check("long_hold", int'(digit_cnt), 1);
      press(4'd3, 2);
      @(negedge clk);
      check("glitch", int'(digit_cnt), 1);
      exp_q.push_back(EV_FAIL);
      press(4'd3, 6);
      press(4'd7, 6);
      press(4'd9, 6);

      // Entry timeout.
      press(4'd1, 6);
      press(4'd3, 6);
      @(negedge clk);
      check("to_cnt_2", int'(digit_cnt), 2);
      repeat (TIMEOUT_CYC - 20) tick();
      @(negedge clk);
      check("to_still_busy", int'(busy), 1);
      repeat (30) tick();
      @(negedge clk);
      check("to_busy", int'(busy), 0);
      check("to_digit_cnt", int'(digit_cnt), 0);
      enter(16'h1379, EV_UNLOCK);

      // Password change while authorised.
      pulse_cmd_set();
      @(negedge clk);
      check("set_busy", int'(busy), 1);
      enter(16'h9977, EV_SET);
      check("after_set_busy", int'(busy), 0);
      enter(16'h9977, EV_UNLOCK);
      enter(16'h1379, EV_FAIL);
      pulse_cmd_set();
      @(negedge clk);
      check("cmd_set_no_auth", int'(busy), 0);

      // Reset mid-entry restores default password.
      press(4'd9, 6);
      press(4'd9, 6);
      press(4'd7, 6);
      @(negedge clk);
      check("pre_rst_cnt", int'(digit_cnt), 3);
      rst = 1'b1;
      tick();
      @(negedge clk);
      check_all_zero("mid_rst");
      rst = 1'b0;
      tick();
      enter(16'h1379, EV_UNLOCK);

      repeat (5) tick();
      check("pending_events", exp_q.size(), 0);
`ifdef LOCKOUT_EN
      check("lock_runs", lock_runs, 1);
`else
      check("lock_runs", lock_runs, 0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
